scv_vram_arbiter: RTL
=====================

// Module: scv_vram_arbiter
// PURPOSE
//  Shares the single-port 1Kx8 VRAM (CPU window 'h3000-'h33FF) between the uPD7800 CPU
//  bus and the video fetch engine. Video normally has priority. A starvation counter
//  guarantees CPU progress. The block stalls the CPU via WAITB until its access is done,
//  and drives the synchronous-read VRAM macro.
// PARAMETERS
//  AW          10  VRAM address width
//  DW          8   data width
//  STARVE_MAX  4   video grants allowed while a CPU access is pending; the next grant then goes to the CPU
// PORTS
//  CLK        in   1   system clock (all state on posedge)
//  RES        in   1   asynchronous, active-high reset
//  CPU_CS     in   1   high = CPU address decodes to VRAM
//  CPU_A      in   AW  CPU address
//  CPU_RDB    in   1   CPU read strobe, active low
//  CPU_WRB    in   1   CPU write strobe, active low
//  CPU_DI     in   DW  CPU write data
//  CPU_DO     out  DW  CPU read data (registered, held)
//  CPU_WAITB  out  1   low = stall CPU
//  VID_REQ    in   1   video fetch request (level)
//  VID_A      in   AW  video fetch address
//  VID_ACK    out  1   1-cycle pulse: VID_A accepted this cycle
//  VID_VALID  out  1   1-cycle pulse: VID_DO valid
//  VID_DO     out  DW  video read data
//  RAM_A      out  AW  VRAM address
//  RAM_WE     out  1   VRAM write enable (sampled by RAM on negedge CLK)
//  RAM_DI     out  DW  VRAM write data
//  RAM_DO     in   DW  VRAM read data, valid 1 CLK after RAM_A
// BEHAVIOUR
//  - Reset values: CPU_DO=0, CPU_WAITB=1, VID_ACK=0, VID_VALID=0, VID_DO=0, RAM_A=0, RAM_WE=0, RAM_DI=0.
//    State is IDLE, starve_cnt=0, served=0.
//  - cpu_req = CPU_CS & ~(CPU_RDB & CPU_WRB).
//  - CPU_WAITB = ~(cpu_req & ~served). This is combinational, so the stall appears in the same cycle as the request.
//  - served is set when the CPU access completes. It clears when cpu_req drops, which re-arms for the next access.
//  - FSM states: IDLE, VID, CPU_RD, CPU_RD2, CPU_WR. Each state lasts 1 CLK unless noted.
//  - Grant is evaluated in IDLE and in VID, so video may be granted back-to-back:
//     1. VID_REQ & ~(cpu_req & ~served & starve_cnt==STARVE_MAX) -> VID: RAM_A=VID_A, VID_ACK=1.
//        If a CPU access is pending, starve_cnt++ (saturating).
//     2. else cpu_req & ~served -> CPU_RD (RDB low) or CPU_WR (WRB low). starve_cnt=0.
//     3. else -> IDLE.
//  - The cycle after each VID grant: VID_VALID=1 and VID_DO=RAM_DO. This is pipelined and independent of the FSM's current state.
//  - CPU_RD: RAM_A=CPU_A. Next state is CPU_RD2.
//  - CPU_RD2: CPU_DO<=RAM_DO, served<=1, then go to IDLE. Total 2 CLK after grant.
//  - CPU_WR: RAM_A=CPU_A, RAM_DI=CPU_DI, RAM_WE=1 for exactly 1 CLK. Then served<=1 and go to IDLE.
//  - RAM_WE=1 only in CPU_WR. Video never writes.
//  - Both RDB and WRB low (illegal): treat as a write.
//  - If cpu_req drops mid-access (CPU_RD/CPU_RD2/CPU_WR), the access still completes.
//    served then clears on the next cycle because cpu_req=0.
//  - Simultaneous VID_REQ and new cpu_req with starve_cnt<STARVE_MAX: video wins.
//    With starve_cnt==STARVE_MAX: CPU wins.
//  - RES mid-access:
//     - All outputs return immediately (asynchronously) to their reset values, RAM_WE=0 included.
//     - An interrupted write may be lost.
//     - A CPU request still held after reset is serviced anew.
//  - CPU_DO holds its last read value until the next CPU read completes.
// TESTING
//  1. Reset, idle, CPU read 'h3005 with RAM[5]='h5A -> CPU_WAITB low 2 CLK; then CPU_DO='h5A, CPU_WAITB=1.
//  2. CPU write 'hA7 to 'h33FF -> exactly one RAM_WE pulse with RAM_A='h3FF, RAM_DI='hA7. Readback gives 'hA7.
//  3. VID_REQ held, addresses 0,1,2,... -> VID_ACK every CLK.
//     VID_VALID every CLK, one cycle later; VID_DO equals RAM[n] in order.
//  4. VID_REQ held plus a CPU read -> exactly 4 video grants, then the CPU is granted.
//     WAITB is low for 4+2 CLK, then video resumes.
//  5. Assert RES during CPU_WR -> RAM_WE=0 same cycle, all outputs at reset values.
//     After release, the still-pending write completes once.
//  6. CPU_RDB released during CPU_RD2 -> CPU_DO still updated, served clears, next access not skipped.

Source files
------------

// File: rtl/scv_vram_arbiter.sv
// ---------------------------------------------------------------------------
// scv_vram_arbiter
//
// Shares the single-port, synchronous-read 1Kx8 VRAM between the uPD7800 CPU
// bus and the video fetch engine. Video normally wins arbitration. A
// starvation counter forces a CPU grant after STARVE_MAX video grants made
// while a CPU access is waiting. The CPU is held off with CPU_WAITB until its
// access has completed.
//
// Handshakes:
//   CPU   : a request is CPU_CS with either strobe low. CPU_WAITB is low while
//           the request is held and not yet served. Once CPU_WAITB reads high
//           with the request still held, the access is finished (read data on
//           CPU_DO). The CPU must drop the request for at least one cycle
//           before the next access.
//   Video : VID_REQ is a level request. VID_ACK high in a cycle means VID_A
//           is sampled by the RAM at the end of that cycle, so the source may
//           move on to its next address. VID_VALID pulses one cycle later,
//           with VID_DO carrying the RAM word.
//
// Ports:
//   CLK, RES             clock, asynchronous active-high reset
//   CPU_CS/A/RDB/WRB/DI  CPU bus request side
//   CPU_DO, CPU_WAITB    CPU read data (held), CPU stall (low = stall)
//   VID_REQ, VID_A       video fetch request and address
//   VID_ACK              address accepted this cycle
//   VID_VALID, VID_DO    fetched data, one cycle after VID_ACK
//   RAM_A/WE/DI, RAM_DO  VRAM macro (WE sampled on negedge, DO 1 CLK after A)
//   DBG_STATE            arbitration phase of the current cycle
// ---------------------------------------------------------------------------
module scv_vram_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          CPU_CS,
    input  logic [AW-1:0] CPU_A,
    input  logic          CPU_RDB,
    input  logic          CPU_WRB,
    input  logic [DW-1:0] CPU_DI,
    output logic [DW-1:0] CPU_DO,
    output logic          CPU_WAITB,
    input  logic          VID_REQ,
    input  logic [AW-1:0] VID_A,
    output logic          VID_ACK,
    output logic          VID_VALID,
    output logic [DW-1:0] VID_DO,
    output logic [AW-1:0] RAM_A,
    output logic          RAM_WE,
    output logic [DW-1:0] RAM_DI,
    input  logic [DW-1:0] RAM_DO,
    output logic [2:0]    DBG_STATE
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_VID     = 3'd1;
    localparam logic [2:0] ST_CPU_RD  = 3'd2;
    localparam logic [2:0] ST_CPU_RD2 = 3'd3;
    localparam logic [2:0] ST_CPU_WR  = 3'd4;

    localparam int            CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [2:0]    state_q, state_d;
    logic [2:0]    cur_state;
    logic [2:0]    out_state;
    logic [CW-1:0] starve_q, starve_d;
    logic          served_q, served_d;
    logic [DW-1:0] cpu_do_q, cpu_do_d;
    logic          vid_valid_q;

    logic cpu_req;
    logic cpu_pend;
    logic cpu_wr;

    assign cpu_req  = CPU_CS & ~(CPU_RDB & CPU_WRB);
    assign cpu_pend = cpu_req & ~served_q;
    // Both strobes low is illegal on the bus; it is handled as a write.
    assign cpu_wr   = ~CPU_WRB;

    // Arbitration is resolved in the same cycle it is evaluated: the winning
    // phase (VID, CPU_RD or CPU_WR) drives the RAM straight away, so a grant
    // costs no extra cycle. Only the read data capture (CPU_RD2) is a
    // registered follow-on phase, and no arbitration happens during it.
    always_comb begin
        cur_state = ST_IDLE;
        starve_d  = starve_q;
        if (state_q == ST_CPU_RD2) begin
            cur_state = ST_CPU_RD2;
        end else if (VID_REQ && !(cpu_pend && (starve_q == STARVE_LIM))) begin
            cur_state = ST_VID;
            if (cpu_pend && (starve_q != STARVE_LIM)) begin
                starve_d = starve_q + 1'b1;
            end
        end else if (cpu_pend) begin
            cur_state = cpu_wr ? ST_CPU_WR : ST_CPU_RD;
            starve_d  = '0;
        end
    end

    always_comb begin
        case (cur_state)
            ST_VID:    state_d = ST_VID;
            ST_CPU_RD: state_d = ST_CPU_RD2;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Completion wins over the clear, so a request dropped during the last
    // access cycle still marks it served; the clear follows a cycle later.
    always_comb begin
        served_d = served_q;
        if ((cur_state == ST_CPU_RD2) || (cur_state == ST_CPU_WR)) begin
            served_d = 1'b1;
        end else if (!cpu_req) begin
            served_d = 1'b0;
        end
    end

    always_comb begin
        cpu_do_d = cpu_do_q;
        if (cur_state == ST_CPU_RD2) begin
            cpu_do_d = RAM_DO;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            served_q    <= 1'b0;
            cpu_do_q    <= '0;
            vid_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            served_q    <= served_d;
            cpu_do_q    <= cpu_do_d;
            vid_valid_q <= (cur_state == ST_VID);
        end
    end

    // While reset is asserted the combinational outputs must also sit at
    // their reset values, even though requests may still be present.
    assign out_state = RES ? ST_IDLE : cur_state;

    always_comb begin
        RAM_A   = '0;
        RAM_WE  = 1'b0;
        RAM_DI  = '0;
        VID_ACK = 1'b0;
        case (out_state)
            ST_VID: begin
                RAM_A   = VID_A;
                VID_ACK = 1'b1;
            end
            ST_CPU_RD: begin
                RAM_A = CPU_A;
            end
            ST_CPU_WR: begin
                RAM_A  = CPU_A;
                RAM_WE = 1'b1;
                RAM_DI = CPU_DI;
            end
            default: begin
            end
        endcase
    end

    assign CPU_WAITB = RES | ~cpu_pend;
    assign CPU_DO    = cpu_do_q;
    assign VID_VALID = vid_valid_q;
    assign VID_DO    = vid_valid_q ? RAM_DO : '0;
    assign DBG_STATE = out_state;

endmodule
